// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads a sync-read instruction memory and hands words to decode over valid/ready.
// Define IFU_PERF_CNT_EN to add the retiredCnt transfer counter port.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imemRen,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic [31:0]       imemData,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectAddr,
  output logic              halt
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       retiredCnt
`endif
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [31:0]       HALT_WORD  = 32'hFFFF_FFFF;

  typedef enum logic {RUN, HALT} state_t;

  state_t state, nextState;

  logic [ADDR_W-1:0] fetchAddr;
  logic              inflight;
  logic [ADDR_W-1:0] inflightPc;
  logic              outValid;
  logic [31:0]       outInstr;
  logic [ADDR_W-1:0] outPc;
  logic              skidValid;
  logic [31:0]       skidInstr;
  logic [ADDR_W-1:0] skidPc;

  logic       haltSeen;
  logic       arriveKeep;
  logic       bypass;
  logic       xfer;
  logic       issue;
  logic [1:0] occupancy;

  // A returning word is shown directly when the output register is empty, so a read issued in
  // cycle t is presented in cycle t+1. Occupancy counts everything that could still need a slot.
  always_comb begin
    haltSeen   = inflight && (state == RUN) && (imemData == HALT_WORD);
    arriveKeep = inflight && (state == RUN) && (imemData != HALT_WORD);
    bypass     = !outValid && arriveKeep;
    instrValid = outValid || arriveKeep;
    xfer       = instrValid && instrReady;
    occupancy  = 2'(outValid) + 2'(skidValid) + 2'(inflight) - 2'(xfer);
  end

  assign instr    = bypass ? imemData : outInstr;
  assign pc       = bypass ? inflightPc : outPc;
  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imemAddr = fetchAddr;
  assign imemRen  = issue && !reset;
  assign halt     = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // A read is only issued when at most one entry remains after this cycle, so its response
  // always finds the output register or the skid free.
  always_comb begin
    nextState = state;
    issue     = 1'b0;
    case (state)
      RUN: begin
        issue = (occupancy <= 2'd1);
        if (!redirect && haltSeen) begin
          nextState = HALT;
        end
      end
      HALT: begin
        if (redirect) begin
          nextState = RUN;
        end
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchAddr  <= RESET_ADDR;
      inflight   <= 1'b0;
      inflightPc <= '0;
      outValid   <= 1'b0;
      outInstr   <= '0;
      outPc      <= '0;
      skidValid  <= 1'b0;
      skidInstr  <= '0;
      skidPc     <= '0;
    end else if (redirect) begin
      fetchAddr <= redirectAddr;
      inflight  <= 1'b0;
      outValid  <= 1'b0;
      skidValid <= 1'b0;
    end else begin
      inflight   <= imemRen;
      inflightPc <= fetchAddr;
      if (imemRen) begin
        fetchAddr <= fetchAddr + 1'b1;
      end
      if (xfer) begin
        if (skidValid) begin
          outInstr  <= skidInstr;
          outPc     <= skidPc;
          skidValid <= arriveKeep;
          if (arriveKeep) begin
            skidInstr <= imemData;
            skidPc    <= inflightPc;
          end
        end else if (outValid) begin
          outValid <= arriveKeep;
          if (arriveKeep) begin
            outInstr <= imemData;
            outPc    <= inflightPc;
          end
        end else begin
          outValid <= 1'b0;
        end
      end else if (!outValid) begin
        outValid <= arriveKeep;
        if (arriveKeep) begin
          outInstr <= imemData;
          outPc    <= inflightPc;
        end
      end else if (arriveKeep) begin
        skidValid <= 1'b1;
        skidInstr <= imemData;
        skidPc    <= inflightPc;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retiredCnt <= '0;
    end else if (xfer) begin
      retiredCnt <= retiredCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: expected instruction streams are derived from the
// memory image and the redirect/reset addresses, then popped by a monitor on every transfer.
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] word;
  } expEntry_t;

  logic        clk;
  logic        reset;
  logic        imemRen;
  logic [7:0]  imemAddr;
  logic [31:0] imemData;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [7:0]  pc;
  logic        redirect;
  logic [7:0]  redirectAddr;
  logic        halt;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] retiredCnt;
  logic [31:0] retiredModel;
`endif

  logic        imemRen2;
  logic [3:0]  imemAddr2;
  logic [31:0] imemData2;
  logic        instrValid2;
  logic [31:0] instr2;
  logic [5:0]  opcode2;
  logic [5:0]  funct2;
  logic [3:0]  pc2;
  logic        halt2;

  logic [31:0] mem  [256];
  logic [31:0] mem2 [16];
  expEntry_t   expQ [$];
  logic [7:0]  lastAccPc;
  logic [7:0]  prevAccPc;
  int          checks;
  int          failures;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .imemRen(imemRen), .imemAddr(imemAddr), .imemData(imemData),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr), .opcode(opcode),
    .funct(funct), .pc(pc), .redirect(redirect), .redirectAddr(redirectAddr), .halt(halt)
`ifdef IFU_PERF_CNT_EN
    , .retiredCnt(retiredCnt)
`endif
  );

  instr_fetch_unit #(.ADDR_W(4), .RESET_PC(14)) dut2 (
    .clk(clk), .reset(reset), .imemRen(imemRen2), .imemAddr(imemAddr2), .imemData(imemData2),
    .instrValid(instrValid2), .instrReady(1'b1), .instr(instr2), .opcode(opcode2),
    .funct(funct2), .pc(pc2), .redirect(1'b0), .redirectAddr(4'd0), .halt(halt2)
`ifdef IFU_PERF_CNT_EN
    , .retiredCnt()
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read memories: data for a read enabled in cycle t is visible in cycle t+1.
  always @(posedge clk) begin
    if (imemRen) imemData <= mem[imemAddr];
    if (imemRen2) imemData2 <= mem2[imemAddr2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the architectural word stream starting at an address, ending before a halt marker.
  function automatic void pushStream(input logic [7:0] start);
    logic [7:0] a;
    expQ.delete();
    a = start;
    for (int k = 0; k < 256; k++) begin
      if (mem[a] == HALT_WORD) break;
      expQ.push_back('{pc: a, word: mem[a]});
      a = a + 8'd1;
    end
  endfunction

  // Monitor: every presented word must be the head of the expected stream; a transfer retires it.
  always @(negedge clk) begin
    if (reset) begin
`ifdef IFU_PERF_CNT_EN
      retiredModel = 0;
`endif
    end else begin
`ifdef IFU_PERF_CNT_EN
      check("retiredCnt", retiredCnt, retiredModel);
`endif
      if (halt) check("haltNoRead", {31'd0, imemRen}, 32'd0);
      if (instrValid) begin
        if (expQ.size() == 0) begin
          check("unexpectedWord", {31'd0, instrValid}, 32'd0);
        end else begin
          check("instr", instr, expQ[0].word);
          check("pc", {24'd0, pc}, {24'd0, expQ[0].pc});
          check("opcode", {26'd0, opcode}, {26'd0, expQ[0].word[31:26]});
          check("funct", {26'd0, funct}, {26'd0, expQ[0].word[5:0]});
          if (instrReady) begin
            void'(expQ.pop_front());
            prevAccPc = lastAccPc;
            lastAccPc = pc;
`ifdef IFU_PERF_CNT_EN
            retiredModel = retiredModel + 32'd1;
`endif
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] target);
    logic expValid;
    redirect     = 1'b1;
    redirectAddr = target;
    @(posedge clk); #1;
    redirect = 1'b0;
    pushStream(target);
    @(negedge clk);
    check("redirN1Valid", {31'd0, instrValid}, 32'd0);
    check("redirN1Ren", {31'd0, imemRen}, 32'd1);
    check("redirN1Addr", {24'd0, imemAddr}, {24'd0, target});
    check("redirN1Halt", {31'd0, halt}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    expValid = (mem[target] != HALT_WORD);
    check("redirN2Valid", {31'd0, instrValid}, {31'd0, expValid});
    if (expValid) check("redirN2Pc", {24'd0, pc}, {24'd0, target});
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "Valid"}, {31'd0, instrValid}, 32'd0);
    check({tag, "Instr"}, instr, 32'd0);
    check({tag, "Op"}, {26'd0, opcode}, 32'd0);
    check({tag, "Funct"}, {26'd0, funct}, 32'd0);
    check({tag, "Pc"}, {24'd0, pc}, 32'd0);
    check({tag, "Halt"}, {31'd0, halt}, 32'd0);
    check({tag, "Ren"}, {31'd0, imemRen}, 32'd0);
    check({tag, "Addr"}, {24'd0, imemAddr}, 32'd0);
  endtask

  task automatic waitHalt();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (halt) break;
    end
    check("haltReached", {31'd0, halt}, 32'd1);
  endtask

  task automatic cycleCheckPc(input logic [7:0] expPc, input string name);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "Valid"}, {31'd0, instrValid}, 32'd1);
    check({name, "Pc"}, {24'd0, pc}, {24'd0, expPc});
  endtask

  // Small-address-space instance: the PC must wrap 14,15,0,1.
  initial begin : wrapCheck
    logic [3:0] expPc [4];
    int got;
    expPc = '{4'd14, 4'd15, 4'd0, 4'd1};
    got = 0;
    @(negedge reset);
    for (int c = 0; c < 12 && got < 4; c++) begin
      @(negedge clk);
      if (instrValid2) begin
        check("wrapPc", {28'd0, pc2}, {28'd0, expPc[got]});
        check("wrapInstr", instr2, mem2[expPc[got]]);
        check("wrapFields", {20'd0, opcode2, funct2}, {20'd0, mem2[expPc[got]][31:26], mem2[expPc[got]][5:0]});
        check("wrapHalt", {31'd0, halt2}, 32'd0);
        got++;
      end
    end
    check("wrapCount", got, 4);
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    checks       = 0;
    failures     = 0;
    lastAccPc    = '0;
    prevAccPc    = '0;
    reset        = 1'b1;
    instrReady   = 1'b1;
    redirect     = 1'b0;
    redirectAddr = '0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT_WORD) w = 32'h0;
      mem[i] = w;
    end
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      if (w == HALT_WORD) w = 32'h1;
      mem2[i] = w;
    end
    mem[8'h05] = HALT_WORD;
    mem[8'h60] = HALT_WORD;
    mem[8'hB0] = HALT_WORD;
    mem[8'hF0] = HALT_WORD;

    $display("[TB] reset and streaming from address 0");
    repeat (3) @(posedge clk);
    #1;
    pushStream(8'd0);
    @(negedge clk);
    checkOutput("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("firstValid", {31'd0, instrValid}, 32'd0);
    check("firstRen", {31'd0, imemRen}, 32'd1);
    check("firstAddr", {24'd0, imemAddr}, 32'd0);
    for (int k = 0; k < 4; k++) cycleCheckPc(8'(k), "stream");

    $display("[TB] halt marker at address 5");
    waitHalt();
    repeat (5) begin
      @(negedge clk);
      check("haltHeldRen", {31'd0, imemRen}, 32'd0);
      check("haltHeldValid", {31'd0, instrValid}, 32'd0);
      check("haltHeld", {31'd0, halt}, 32'd1);
    end
    check("haltDrained", expQ.size(), 0);

    $display("[TB] redirect out of halt, then stall on word 1");
    @(posedge clk); #1;
    applyStimulus(8'd0);
    @(posedge clk); #1;
    instrReady = 1'b0;
    @(negedge clk);
    check("stallValid", {31'd0, instrValid}, 32'd1);
    check("stallPc", {24'd0, pc}, 32'd1);
    repeat (2) cycleCheckPc(8'd1, "stall");
    @(posedge clk); #1;
    instrReady = 1'b1;
    @(negedge clk);
    check("resumePc", {24'd0, pc}, 32'd1);
    cycleCheckPc(8'd2, "resume");
    cycleCheckPc(8'd3, "resume");
    waitHalt();

    $display("[TB] redirect to 0x40 while word 1 transfers");
    @(posedge clk); #1;
    applyStimulus(8'd0);
    @(posedge clk); #1;
    applyStimulus(8'h40);
    @(posedge clk); #1;
    check("redirAcceptedOld", {24'd0, prevAccPc}, 32'd1);
    check("redirAcceptedNew", {24'd0, lastAccPc}, 32'h40);

    $display("[TB] reset while stalled with a read in flight");
    repeat (3) @(posedge clk);
    #1;
    instrReady = 1'b0;
    @(negedge clk);
    check("preResetValid", {31'd0, instrValid}, 32'd1);
    check("preResetRen", {31'd0, imemRen}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    pushStream(8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midReset");
`ifdef IFU_PERF_CNT_EN
    check("retiredReset", retiredCnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset      = 1'b0;
    instrReady = 1'b1;
    @(negedge clk);
    check("restartRen", {31'd0, imemRen}, 32'd1);
    check("restartAddr", {24'd0, imemAddr}, 32'd0);
    cycleCheckPc(8'd0, "restart");

    $display("[TB] randomized ready and redirect traffic");
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      instrReady = ($urandom_range(0, 3) != 0);
      if (($urandom_range(0, 39) == 0) || (halt && ($urandom_range(0, 3) == 0))) begin
        applyStimulus(8'($urandom_range(0, 255)));
      end
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
